// File: rtl/scalar_rf_pkg.sv
// Shared definitions for the scalar register-file host port: FSM state
// encoding and default geometry of the attached register file.
package scalar_rf_pkg;

  localparam int unsigned DEF_REG_DEPTH  = 6;
  localparam int unsigned DEF_REG_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_LEN_WIDTH  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } host_state_e;

endpackage

// File: rtl/scalar_rf_host_port.sv
// Host request/response port in front of the scalar register file.
// Writes are single beat; reads are bursts of req_len+1 beats. Addresses at or
// beyond REG_DEPTH are reported with rsp_err and never touch the register file.
module scalar_rf_host_port
  import scalar_rf_pkg::*;
#(
  parameter int unsigned REG_DEPTH  = DEF_REG_DEPTH,
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  // Request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [REG_WIDTH-1:0]  req_wdata,
  // Response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_last,
  // Register-file side
  output logic [ADDR_WIDTH-1:0] rf_read_address,
  input  logic [REG_WIDTH-1:0]  rf_read_data,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [REG_WIDTH-1:0]  rf_write_data,
  output logic                  rf_write_enable
);

  host_state_e           r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [LEN_WIDTH-1:0]  r_cnt, w_cnt_next;
  logic [REG_WIDTH-1:0]  r_wdata, w_wdata_next;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [REG_WIDTH-1:0]  r_rsp_rdata, w_rsp_rdata_next;
  logic                  r_rsp_err, w_rsp_err_next;
  logic                  r_rsp_last, w_rsp_last_next;
  logic [31:0]           w_addr_ext;
  logic                  w_oob;

  // Current address lies outside the implemented registers.
  assign w_addr_ext = 32'(r_addr);
  assign w_oob      = (w_addr_ext >= REG_DEPTH);

  // Next-state and response-capture logic.
  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_cnt_next       = r_cnt;
    w_wdata_next     = r_wdata;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    w_rsp_last_next  = r_rsp_last;
    unique case (r_state)
      IDLE: begin
        // r_req_ready gates acceptance so the first cycle after reset is idle.
        if (req_valid && r_req_ready) begin
          w_addr_next = req_addr;
          if (req_write) begin
            w_state_next = WR;
            w_wdata_next = req_wdata;
            w_cnt_next   = '0;
          end else begin
            w_state_next = RD;
            w_cnt_next   = req_len;
          end
        end
      end
      WR: begin
        w_state_next     = RSP;
        w_rsp_rdata_next = '0;
        w_rsp_err_next   = w_oob;
        w_rsp_last_next  = 1'b1;
      end
      RD: begin
        w_state_next     = RSP;
        w_rsp_rdata_next = w_oob ? '0 : rf_read_data;
        w_rsp_err_next   = w_oob;
        w_rsp_last_next  = (r_cnt == '0);
      end
      RSP: begin
        if (rsp_ready) begin
          if (r_cnt != '0) begin
            w_state_next = RD;
            w_addr_next  = r_addr + ADDR_WIDTH'(1);
            w_cnt_next   = r_cnt - LEN_WIDTH'(1);
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_cnt       <= w_cnt_next;
      r_wdata     <= w_wdata_next;
      r_req_ready <= (w_state_next == IDLE);
      r_rsp_valid <= (w_state_next == RSP);
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_last  <= w_rsp_last_next;
    end
  end

  assign req_ready        = r_req_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_err          = r_rsp_err;
  assign rsp_last         = r_rsp_last;
  assign rf_read_address  = r_addr;
  assign rf_write_address = r_addr;
  assign rf_write_data    = r_wdata;
  assign rf_write_enable  = (r_state == WR) && !w_oob;

endmodule

// File: tb/tb_scalar_rf_host_port.sv
// Directed bench for scalar_rf_host_port with a behavioural register file.
module tb_scalar_rf_host_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [1:0]  req_len = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;
  logic [4:0]  rf_read_address;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;

  int n_cmp = 0;
  int n_bad = 0;

  scalar_rf_host_port dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .rsp_last         (rsp_last),
    .rf_read_address  (rf_read_address),
    .rf_read_data     (rf_read_data),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_enable  (rf_write_enable)
  );

  always #5 clk = ~clk;

  // Register file model: 32 entries so out-of-range reads return junk the DUT must hide.
  logic [31:0] mem [32];
  logic        init_done = 1'b0;
  int          we_count = 0;
  assign rf_read_data = mem[rf_read_address];

  // Preload the model once, then apply write-enable pulses and count them.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i < 6) ? (32'h1000_0000 + i) : (32'hBAD0_0000 + i);
      init_done <= 1'b1;
    end else if (rf_write_enable) begin
      mem[rf_write_address] <= rf_write_data;
      we_count <= we_count + 1;
    end
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    int          nbeats;
    logic [3:0][31:0] rdata;
    logic [3:0]  err;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [4:0] addr, input logic [1:0] len,
                              input logic [31:0] wdata, input int nbeats,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3,
                              input logic [3:0] err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.wdata = wdata; v.nbeats = nbeats;
    v.rdata[0] = r0; v.rdata[1] = r1; v.rdata[2] = r2; v.rdata[3] = r3;
    v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) at negedges until rsp_valid is seen.
  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rsp_wait"}, rsp_valid, 1);
  endtask

  // Present one request at a negedge and return #1 after the accepting edge.
  task automatic send_req(input string name, input logic wr, input logic [4:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    we0;
    string nm;
    we0 = we_count;
    nm = $sformatf("v%0d", idx);
    rsp_ready = 1'b1;
    send_req(nm, v.wr, v.addr, v.len, v.wdata);
    @(negedge clk);
    check({nm, "_t1_rsp_valid"}, rsp_valid, 0);
    check({nm, "_t1_req_ready"}, req_ready, 0);
    if (v.wr) begin
      check({nm, "_t1_we"}, rf_write_enable, !v.err[0]);
      check({nm, "_t1_waddr"}, rf_write_address, v.addr);
      check({nm, "_t1_wdata"}, rf_write_data, v.wdata);
    end else begin
      check({nm, "_t1_raddr"}, rf_read_address, v.addr);
      check({nm, "_t1_we"}, rf_write_enable, 0);
    end
    @(negedge clk);
    check({nm, "_t2_rsp_valid"}, rsp_valid, 1);
    for (int b = 0; b < v.nbeats; b++) begin
      if (b > 0) begin
        @(negedge clk);
        wait_rsp($sformatf("%s_b%0d", nm, b));
      end
      check($sformatf("%s_b%0d_rdata", nm, b), rsp_rdata, v.rdata[b]);
      check($sformatf("%s_b%0d_err", nm, b), rsp_err, v.err[b]);
      check($sformatf("%s_b%0d_last", nm, b), rsp_last, (b == v.nbeats - 1));
      check($sformatf("%s_b%0d_req_ready", nm, b), req_ready, 0);
      @(posedge clk);
    end
    @(negedge clk);
    check({nm, "_end_rsp_valid"}, rsp_valid, 0);
    check({nm, "_we_count"}, we_count - we0, (v.wr && !v.err[0]) ? 1 : 0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] held;
    int          we0;

    vecs[0] = mk(1, 5'd3,  2'd0, 32'hDEAD_BEEF, 1, 32'h0, 0, 0, 0, 4'b0000);
    vecs[1] = mk(0, 5'd3,  2'd0, 32'h0, 1, 32'hDEAD_BEEF, 0, 0, 0, 4'b0000);
    vecs[2] = mk(1, 5'd4,  2'd0, 32'h1234_5678, 1, 32'h0, 0, 0, 0, 4'b0000);
    vecs[3] = mk(1, 5'd5,  2'd0, 32'hA5A5_0F0F, 1, 32'h0, 0, 0, 0, 4'b0000);
    vecs[4] = mk(0, 5'd4,  2'd3, 32'h0, 4, 32'h1234_5678, 32'hA5A5_0F0F, 0, 0, 4'b1100);
    vecs[5] = mk(1, 5'd7,  2'd0, 32'hFFFF_FFFF, 1, 32'h0, 0, 0, 0, 4'b0001);
    vecs[6] = mk(1, 5'd0,  2'd3, 32'h0000_0001, 1, 32'h0, 0, 0, 0, 4'b0000);
    vecs[7] = mk(0, 5'd31, 2'd1, 32'h0, 2, 32'h0, 32'h0000_0001, 0, 0, 4'b0001);
    vecs[8] = mk(0, 5'd1,  2'd1, 32'h0, 2, 32'h1000_0001, 32'h1000_0002, 0, 0, 4'b0000);
    vecs[9] = mk(0, 5'd5,  2'd2, 32'h0, 3, 32'hA5A5_0F0F, 0, 0, 0, 4'b0110);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_we", rf_write_enable, 0);
    check("rst_raddr", rf_read_address, 0);
    check("rst_waddr", rf_write_address, 0);
    check("rst_wdata", rf_write_data, 0);
    reset = 1'b0;
    #1 check("rel_req_ready_low", req_ready, 0);
    @(posedge clk);
    #1 check("rel_req_ready_high", req_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Backpressure: hold the first beat for five cycles.
    rsp_ready = 1'b0;
    send_req("stall", 1'b0, 5'd0, 2'd2, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("stall_first_valid", rsp_valid, 1);
    held = rsp_rdata;
    check("stall_first_rdata", held, 32'h0000_0001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d_valid", c), rsp_valid, 1);
      check($sformatf("stall_c%0d_rdata", c), rsp_rdata, held);
      check($sformatf("stall_c%0d_err", c), rsp_err, 0);
      check($sformatf("stall_c%0d_last", c), rsp_last, 0);
      check($sformatf("stall_c%0d_req_ready", c), req_ready, 0);
      check($sformatf("stall_c%0d_raddr", c), rf_read_address, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_rsp("stall_b1");
    check("stall_b1_rdata", rsp_rdata, 32'h1000_0001);
    check("stall_b1_last", rsp_last, 0);
    @(posedge clk);
    @(negedge clk);
    wait_rsp("stall_b2");
    check("stall_b2_rdata", rsp_rdata, 32'h1000_0002);
    check("stall_b2_last", rsp_last, 1);
    @(posedge clk);

    // Reset during beat 2 of a four-beat burst.
    send_req("rstb", 1'b0, 5'd0, 2'd3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    wait_rsp("rstb_b0");
    @(posedge clk);
    @(negedge clk);
    wait_rsp("rstb_b1");
    check("rstb_b1_rdata", rsp_rdata, 32'h1000_0001);
    #2 reset = 1'b1;
    #1;
    check("rstb_rsp_valid", rsp_valid, 0);
    check("rstb_req_ready", req_ready, 0);
    check("rstb_rsp_rdata", rsp_rdata, 0);
    check("rstb_rsp_last", rsp_last, 0);
    check("rstb_raddr", rf_read_address, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rstb_rel_ready_low", req_ready, 0);
    @(posedge clk);
    #1 check("rstb_rel_ready_high", req_ready, 1);
    check("rstb_post_valid", rsp_valid, 0);
    run_vec(mk(0, 5'd3, 2'd0, 32'h0, 1, 32'hDEAD_BEEF, 0, 0, 0, 4'b0000), 10);

    // Reset while the write-enable cycle is in flight.
    we0 = we_count;
    send_req("rstw", 1'b1, 5'd2, 2'd0, 32'hCAFE_F00D);
    @(negedge clk);
    check("rstw_we_before", rf_write_enable, 1);
    reset = 1'b1;
    #1 check("rstw_we_after", rf_write_enable, 0);
    @(negedge clk);
    check("rstw_we_count", we_count - we0, 0);
    check("rstw_mem", mem[2], 32'h1000_0002);
    check("rstw_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rstw_we_idle", rf_write_enable, 0);
    check("rstw_rsp_idle", rsp_valid, 0);
    run_vec(mk(0, 5'd2, 2'd0, 32'h0, 1, 32'h1000_0002, 0, 0, 0, 4'b0000), 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/scalar_rf_host_port.md
SCALAR_RF_HOST_PORT -- requirements
Module: scalar_rf_host_port

Interface
REQ-001 The block SHALL have parameter REG_DEPTH, default 6, meaning the number of implemented scalar registers.
REQ-002 The block SHALL have parameter REG_WIDTH, default 32, meaning the data width of one register.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the register address width.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 2, meaning the read burst length field width (beats = req_len+1).
REQ-005 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have the request channel: req_valid in 1, req_ready out 1, req_write in 1, req_addr in ADDR_WIDTH, req_len in LEN_WIDTH, req_wdata in REG_WIDTH.
REQ-008 The block SHALL have the response channel: rsp_valid out 1, rsp_ready in 1, rsp_rdata out REG_WIDTH, rsp_err out 1, rsp_last out 1.
REQ-009 The block SHALL have the register-file side: rf_read_address out ADDR_WIDTH, rf_read_data in REG_WIDTH (combinational read), rf_write_address out ADDR_WIDTH, rf_write_data out REG_WIDTH, rf_write_enable out 1.

Function
REQ-010 The FSM SHALL have states IDLE, WR, RD, RSP.
REQ-011 req_ready SHALL be a registered output, 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid && req_ready.
REQ-012 On write acceptance in cycle T, the FSM SHALL go to WR; in T+1 rf_write_enable SHALL be 1 for exactly one cycle with captured address/data, then go to RSP.
REQ-013 On read acceptance in cycle T, the FSM SHALL go to RD with beat counter = req_len; in RD rf_read_address SHALL equal the current address and rf_read_data SHALL be captured into rsp_rdata, then go to RSP (first rsp_valid at T+2).
REQ-014 req_len SHALL be ignored for writes (always single beat).
REQ-015 In RSP, rsp_valid, rsp_rdata, rsp_err, rsp_last SHALL be held stable until rsp_valid && rsp_ready.
REQ-016 On response handshake: if beats remain, address SHALL increment by 1 (modulo 2^ADDR_WIDTH), counter decrement, go to RD; otherwise go to IDLE.
REQ-017 rsp_last SHALL be 1 for the final beat and for every write response.
REQ-018 Any access with address >= REG_DEPTH SHALL set rsp_err=1; an erroneous write SHALL NOT assert rf_write_enable; an erroneous read beat SHALL return rsp_rdata=0.
REQ-019 A burst crossing REG_DEPTH SHALL continue, returning in-range beats normally and out-of-range beats with rsp_err=1.
REQ-020 Write responses SHALL have rsp_rdata=0.
REQ-021 rsp_valid SHALL be 0 outside RSP; req_ready SHALL be 0 outside IDLE, so request and response handshakes never overlap.
REQ-022 rf_write_enable SHALL be 0 in every state except a valid WR cycle.

Reset
REQ-023 Reset SHALL force IDLE and, immediately, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_last=0, rf_write_enable=0, rf_read_address=0, rf_write_address=0, rf_write_data=0.
REQ-024 req_ready SHALL become 1 on the first clk edge after reset deasserts.
REQ-025 Reset mid-burst or mid-write SHALL abort the operation with no further rf_write_enable and no pending response.

Structure
REQ-026 State enum and parameter defaults SHALL live in shared package scalar_rf_pkg.
REQ-027 No sub-module SHALL be required; the block SHALL connect directly to Scalar_Register_File.

Verification
REQ-028 Write addr 3 data 0xDEADBEEF -> rf_write_enable one cycle at T+1, rsp_valid at T+2, err=0, last=1, rdata=0.
REQ-029 Read addr 3 len 0 after REQ-028 -> single response rdata=0xDEADBEEF, err=0, last=1 at T+2.
REQ-030 Read addr 4 len 3, REG_DEPTH=6 -> beats addr 4,5 err=0; addr 6,7 err=1 rdata=0; last only on beat 4.
REQ-031 Write addr 7 -> rsp_err=1, rf_write_enable never asserted.
REQ-032 rsp_ready held 0 for 5 cycles mid-burst -> response fields stable, req_ready=0, no address advance.
REQ-033 Reset asserted during beat 2 of len-3 burst -> rsp_valid=0 immediately, req_ready=1 one edge after release, new request served normally.
